// File: rtl/hazard_pkg.sv
// Shared types for the pipeline interlock controller: MUL/DIV FSM states,
// stall-cause encoding and the register-match helper.
package hazard_pkg;

  typedef enum logic {
    S_RUN,
    S_MD
  } mdState_t;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_LOADUSE,
    CAUSE_BRANCH,
    CAUSE_MD
  } stallCause_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $0 never creates a dependency.
  function automatic logic regMatch(
    input logic [4:0] x,
    input logic [4:0] rs,
    input logic       useRs,
    input logic [4:0] rt,
    input logic       useRt
  );
    return (x != REG_ZERO) &&
           ((x == rs && useRs) || (x == rt && useRt));
  endfunction

endpackage

// File: rtl/md_occupancy_cnt.sv
// Down-counter tracking how many more cycles a MUL/DIV keeps EX.
// Ports: iCLK/iRST_n, iLoad+iLoadVal, iDec, oZero.
module md_occupancy_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iLoad,
  input  logic [CNT_W-1:0] iLoadVal,
  input  logic             iDec,
  output logic             oZero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cnt <= '0;
    end else if (iLoad) begin
      cnt <= iLoadVal;
    end else if (iDec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign oZero = (cnt == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Interlock controller: load-use / branch-operand stalls, MUL/DIV EX
// occupancy, memory-wait freeze and taken-branch flush. Optional
// stall statistics are built when HAZARD_STATS_EN is defined.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = $clog2(MD_CYCLES) + 1,
  parameter int STAT_W    = 32
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [4:0]        iID_NumRs,
  input  logic [4:0]        iID_NumRt,
  input  logic              iID_UseRs,
  input  logic              iID_UseRt,
  input  logic              iID_IsBranch,
  input  logic              iID_BranchTaken,
  input  logic [4:0]        iEX_NumRd,
  input  logic              iEX_RegWrite,
  input  logic              iEX_MemRead,
  input  logic [4:0]        iMEM_NumRd,
  input  logic              iMEM_MemRead,
  input  logic              iEX_MDStart,
  input  logic              iMemWait,
  output logic              oHoldPC,
  output logic              oHoldIFID,
  output logic              oBubbleIDEX,
  output logic              oHoldEX,
  output logic              oFlushIFID,
  output logic              oFreeze,
  output logic              oMDBusy,
  output logic [STAT_W-1:0] oStatLoadUse,
  output logic [STAT_W-1:0] oStatBranch,
  output logic [STAT_W-1:0] oStatMD
);

  localparam bit MD_SEQ = (MD_CYCLES > 1);
  localparam int LOAD_I = MD_SEQ ? MD_CYCLES - 2 : 0;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_I);

  mdState_t    state, stateNext;
  stallCause_t cause;
  logic        mdHold, cntLoad, cntDec, cntZero;
  logic        loadUse, brHaz, active;

  md_occupancy_cnt #(.CNT_W(CNT_W)) uCnt (
    .iCLK     (iCLK),
    .iRST_n   (iRST_n),
    .iLoad    (cntLoad),
    .iLoadVal (LOAD_VAL),
    .iDec     (cntDec),
    .oZero    (cntZero)
  );

  assign loadUse = iEX_MemRead &&
    regMatch(iEX_NumRd, iID_NumRs, iID_UseRs,
             iID_NumRt, iID_UseRt);

  assign brHaz = iID_IsBranch && (
    (iEX_RegWrite &&
     regMatch(iEX_NumRd, iID_NumRs, iID_UseRs,
              iID_NumRt, iID_UseRt)) ||
    (iMEM_MemRead &&
     regMatch(iMEM_NumRd, iID_NumRs, iID_UseRs,
              iID_NumRt, iID_UseRt)));

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= S_RUN;
    else         state <= stateNext;
  end

  // The first MUL/DIV cycle holds from S_RUN, so S_MD only needs
  // MD_CYCLES-2 further hold cycles plus one release cycle.
  always_comb begin
    stateNext = state;
    mdHold    = 1'b0;
    cntLoad   = 1'b0;
    cntDec    = 1'b0;
    unique case (state)
      S_RUN: begin
        if (iEX_MDStart && MD_SEQ) begin
          mdHold = 1'b1;
          if (!iMemWait) begin
            cntLoad   = 1'b1;
            stateNext = S_MD;
          end
        end
      end
      S_MD: begin
        if (!cntZero) begin
          mdHold = 1'b1;
          cntDec = !iMemWait;
        end else if (!iMemWait) begin
          stateNext = S_RUN;
        end
      end
    endcase
  end

  always_comb begin
    cause = CAUSE_NONE;
    unique case (1'b1)
      mdHold:                      cause = CAUSE_MD;
      !mdHold && loadUse:          cause = CAUSE_LOADUSE;
      !mdHold && !loadUse && brHaz: cause = CAUSE_BRANCH;
      default:                     cause = CAUSE_NONE;
    endcase
  end

  assign active  = iRST_n && !iMemWait;
  assign oFreeze = iRST_n && iMemWait;
  assign oMDBusy = active && (state == S_MD);

  always_comb begin
    oHoldPC     = 1'b0;
    oHoldIFID   = 1'b0;
    oBubbleIDEX = 1'b0;
    oHoldEX     = 1'b0;
    oFlushIFID  = 1'b0;
    if (active) begin
      unique case (cause)
        CAUSE_MD: begin
          oHoldEX   = 1'b1;
          oHoldPC   = 1'b1;
          oHoldIFID = 1'b1;
        end
        CAUSE_LOADUSE, CAUSE_BRANCH: begin
          oHoldPC     = 1'b1;
          oHoldIFID   = 1'b1;
          oBubbleIDEX = 1'b1;
        end
        CAUSE_NONE: oFlushIFID = iID_BranchTaken;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] statLU, statBr, statMD;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      statLU <= '0;
      statBr <= '0;
      statMD <= '0;
    end else if (active) begin
      unique case (cause)
        CAUSE_LOADUSE: if (statLU != '1) statLU <= statLU + 1'b1;
        CAUSE_BRANCH:  if (statBr != '1) statBr <= statBr + 1'b1;
        CAUSE_MD:      if (statMD != '1) statMD <= statMD + 1'b1;
        CAUSE_NONE:    ;
      endcase
    end
  end

  assign oStatLoadUse = statLU;
  assign oStatBranch  = statBr;
  assign oStatMD      = statMD;
`else
  assign oStatLoadUse = '0;
  assign oStatBranch  = '0;
  assign oStatMD      = '0;
`endif

endmodule
